fifo_rr_wr_arbiter: RTL and testbench

- Shares the write port of one FIFO (fifo_8_1 class: wr_en/wr_data/rd_en, depth 8) between NREQ producers.
- Arbitration is round-robin. The registered write is driven straight into the FIFO.
- Overflow is prevented by an internal credit counter that tracks free FIFO slots from issued writes and observed reads. The FIFO's own full flag is not used, so there is no stale-flag hazard.

---
 rtl/fifo_rr_wr_arbiter.sv | 88 ++++++++
 tb/tb_fifo_rr_wr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers.
// A credit counter of free FIFO slots replaces the FIFO's full flag.
module fifo_rr_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 4,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 fifo_rd_en,
    output logic [NREQ-1:0]      ack,
    output logic                 fifo_wr_en,
    output logic [DW-1:0]        fifo_wr_data,
    output logic [CW-1:0]        credits,
    output logic                 busy
);

    localparam int              PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0]   LAST_C  = PW'(NREQ - 1);

    logic [NREQ-1:0] lock_r;
    logic [PW-1:0]   ptr_r;
    logic [NREQ-1:0] elig_s;
    logic [NREQ-1:0] grant_oh_s;
    logic [PW-1:0]   grant_idx_s;
    logic [PW-1:0]   ptr_next_s;
    logic            grant_v_s;
    logic            rd_eff_s;
    logic [CW-1:0]   credits_next_s;
    logic [DW-1:0]   data_sel_s;

    // Grant selection, selected data and next credit count.
    always_comb begin
        elig_s      = req & ~lock_r;
        grant_idx_s = {PW{1'b0}};
        data_sel_s  = {DW{1'b0}};
        // Scan offsets from the far end so the one closest to ptr wins.
        for (int off = NREQ - 1; off >= 0; off--) begin
            int            idx;
            logic [PW-1:0] idx_p;
            idx         = (int'(ptr_r) + off) % NREQ;
            idx_p       = idx[PW-1:0];
            grant_idx_s = elig_s[idx_p] ? idx_p : grant_idx_s;
        end
        for (int i = 0; i < NREQ; i++) begin
            data_sel_s = (grant_idx_s == PW'(i)) ? req_data[i*DW +: DW] : data_sel_s;
        end
        grant_v_s  = (|elig_s) && (credits != {CW{1'b0}});
        grant_oh_s = NREQ'(1) << grant_idx_s;
        ptr_next_s = (grant_idx_s == LAST_C) ? {PW{1'b0}} : grant_idx_s + PW'(1);
        // A read while the FIFO is empty is ignored by the FIFO, so it frees nothing.
        rd_eff_s       = fifo_rd_en && (credits != DEPTH_C);
        credits_next_s = credits - CW'(grant_v_s) + CW'(rd_eff_s);
    end

    // Registered write port, acknowledge, round-robin state and credits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack          <= {NREQ{1'b0}};
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= {DW{1'b0}};
            credits      <= DEPTH_C;
            ptr_r        <= {PW{1'b0}};
            lock_r       <= {NREQ{1'b0}};
        end else if (grant_v_s) begin
            ack          <= grant_oh_s;
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= data_sel_s;
            credits      <= credits_next_s;
            ptr_r        <= ptr_next_s;
            lock_r       <= grant_oh_s;
        end else begin
            ack          <= {NREQ{1'b0}};
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= fifo_wr_data;
            credits      <= credits_next_s;
            ptr_r        <= ptr_r;
            lock_r       <= {NREQ{1'b0}};
        end
    end

    assign busy = (|req) && (credits == {CW{1'b0}});

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Self-checking bench for fifo_rr_wr_arbiter (NREQ=4, DW=4, DEPTH=8) with a
// scoreboard of expected writes popped whenever the DUT issues one.
module tb_fifo_rr_wr_arbiter;

    typedef struct packed {
        logic [3:0] ack;
        logic [3:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic        fifo_rd_en;
    logic [3:0]  ack;
    logic        fifo_wr_en;
    logic [3:0]  fifo_wr_data;
    logic [3:0]  credits;
    logic        busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    fifo_rr_wr_arbiter #(.NREQ(4), .DW(4), .DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .fifo_rd_en   (fifo_rd_en),
        .ack          (ack),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .credits      (credits),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every write must match the oldest pending expectation.
    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: ack=%b data=%h, required no write", ack, fifo_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (ack !== mon_e.ack || fifo_wr_data !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL write_match: ack=%b data=%h, required ack=%b data=%h",
                             ack, fifo_wr_data, mon_e.ack, mon_e.data);
                end
            end
        end else if (ack !== 4'b0000) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_without_write: ack=%b wr_en=%b, required ack=0000", ack, fifo_wr_en);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req        = 4'b0000;
        fifo_rd_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: %0d writes missing, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst      = 1'b1;
        req      = 4'hF;
        req_data = 16'h4321;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (ack !== 4'b0000 || fifo_wr_en !== 1'b0 || credits !== 4'd8) begin
                n_fail++;
                $display("FAIL reset_state: ack=%b wr_en=%b credits=%0d, required 0000/0/8",
                         ack, fifo_wr_en, credits);
            end
        end
        rst = 1'b0;
        exp_q.push_back(exp_t'{4'b0001, 4'h1});
        tick();
        n_tests++;
        if (ack !== 4'b0001 || credits !== 4'd7) begin
            n_fail++;
            $display("FAIL first_grant: ack=%b credits=%0d, required 0001/7", ack, credits);
        end
        req = 4'b0000;
        tick();
        tick();
        check_drained("reset");
    endtask

    task automatic test_single();
        logic       exp_en;
        logic [3:0] exp_c;
        do_reset();
        req_data = 16'h0500;
        req      = 4'b0100;
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_t'{4'b0100, 4'h5});
        for (int c = 0; c < 20; c++) begin
            tick();
            exp_en = (c < 16) && (c % 2 == 0);
            exp_c  = (c < 16) ? 4'(7 - c / 2) : 4'd0;
            n_tests++;
            if (fifo_wr_en !== exp_en || credits !== exp_c) begin
                n_fail++;
                $display("FAIL single_cycle%0d: wr_en=%b credits=%0d, required %b/%0d",
                         c, fifo_wr_en, credits, exp_en, exp_c);
            end
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy: busy=%b, required 1", busy);
        end
        req = 4'b0000;
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_noreq: busy=%b, required 0", busy);
        end
        check_drained("single");
    endtask

    task automatic test_all_four();
        logic [3:0] one;
        logic       exp_en;
        logic [3:0] exp_c;
        one = 4'b0001;
        do_reset();
        req_data = 16'h4321;
        req      = 4'hF;
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_t'{one << (i % 4), 4'(i % 4 + 1)});
        for (int c = 0; c < 12; c++) begin
            tick();
            exp_en = (c < 8);
            exp_c  = (c < 8) ? 4'(7 - c) : 4'd0;
            n_tests++;
            if (fifo_wr_en !== exp_en || credits !== exp_c) begin
                n_fail++;
                $display("FAIL all4_cycle%0d: wr_en=%b credits=%0d, required %b/%0d",
                         c, fifo_wr_en, credits, exp_en, exp_c);
            end
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL all4_busy: busy=%b, required 1", busy);
        end
        check_drained("all4");
    endtask

    // Continues from the empty-credit state left by test_all_four.
    task automatic test_credit_return();
        fifo_rd_en = 1'b1;
        tick();
        fifo_rd_en = 1'b0;
        n_tests++;
        if (credits !== 4'd1 || fifo_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_return: credits=%0d wr_en=%b, required 1/0", credits, fifo_wr_en);
        end
        exp_q.push_back(exp_t'{4'b0001, 4'h1});
        tick();
        n_tests++;
        if (fifo_wr_en !== 1'b1 || credits !== 4'd0) begin
            n_fail++;
            $display("FAIL credit_regrant: wr_en=%b credits=%0d, required 1/0", fifo_wr_en, credits);
        end
        tick();
        n_tests++;
        if (fifo_wr_en !== 1'b0 || credits !== 4'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL credit_stall: wr_en=%b credits=%0d busy=%b, required 0/0/1",
                     fifo_wr_en, credits, busy);
        end
        req = 4'b0000;
        tick();
        check_drained("credit");
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_c;
        do_reset();
        req_data = 16'h0700;
        req      = 4'b0100;
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_t'{4'b0100, 4'h7});
        for (int c = 0; c < 6; c++) begin
            tick();
            exp_c = 4'(7 - c / 2);
            n_tests++;
            if (credits !== exp_c) begin
                n_fail++;
                $display("FAIL simul_ramp%0d: credits=%0d, required %0d", c, credits, exp_c);
            end
        end
        fifo_rd_en = 1'b1;
        tick();
        n_tests++;
        if (fifo_wr_en !== 1'b1 || credits !== 4'd5) begin
            n_fail++;
            $display("FAIL simul_grant_read: wr_en=%b credits=%0d, required 1/5", fifo_wr_en, credits);
        end
        fifo_rd_en = 1'b0;
        req        = 4'b0000;
        tick();
        check_drained("simul");
        do_reset();
        fifo_rd_en = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_tests++;
            if (credits !== 4'd8 || fifo_wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL saturate%0d: credits=%0d wr_en=%b, required 8/0", c, credits, fifo_wr_en);
            end
        end
        fifo_rd_en = 1'b0;
    endtask

    task automatic test_reset_midburst();
        do_reset();
        req_data = 16'h4321;
        req      = 4'hF;
        exp_q.push_back(exp_t'{4'b0001, 4'h1});
        exp_q.push_back(exp_t'{4'b0010, 4'h2});
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (ack !== 4'b0000 || fifo_wr_en !== 1'b0 || credits !== 4'd8) begin
            n_fail++;
            $display("FAIL async_reset: ack=%b wr_en=%b credits=%0d, required 0000/0/8",
                     ack, fifo_wr_en, credits);
        end
        @(negedge clk);
        exp_q.push_back(exp_t'{4'b0001, 4'h1});
        rst = 1'b0;
        tick();
        n_tests++;
        if (ack !== 4'b0001 || credits !== 4'd7) begin
            n_fail++;
            $display("FAIL post_reset_grant: ack=%b credits=%0d, required 0001/7", ack, credits);
        end
        req = 4'b0000;
        tick();
        check_drained("midburst");
    endtask

    initial begin
        rst        = 1'b1;
        req        = 4'b0000;
        req_data   = 16'h0000;
        fifo_rd_en = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_credit_return();
        test_simultaneous();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
